// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one synchronous memory bus between the instruction-fetch port (IF)
// and the data-access port (MEM) of a 5-stage pipeline. A fixed-priority FSM
// (MEM over IF, no preemption) serialises requests onto registered bus
// signals. Completion is a one-cycle ack pulse per port. A watchdog aborts
// transactions the slave never acknowledges.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   if_req_i        fetch request, held until if_ack_o
//   if_addr_i       fetch address
//   if_data_o       fetched instruction, valid with if_ack_o, held otherwise
//   if_ack_o        one-cycle fetch completion pulse
//   mem_req_i       data request, held until mem_ack_o
//   mem_we_i        1 = write
//   mem_sel_i       byte enables
//   mem_addr_i      data address
//   mem_wdata_i     write data
//   mem_rdata_o     read data, valid with mem_ack_o, held otherwise
//   mem_ack_o       one-cycle data completion pulse
//   bus_ce_o        bus cycle active
//   bus_we_o        bus write
//   bus_sel_o       bus byte enables
//   bus_addr_o      bus address
//   bus_wdata_o     bus write data
//   bus_rdata_i     bus read data, valid with bus_ack_i
//   bus_ack_i       slave completion (ignored while idle)
//   stallreq_if_o   combinational fetch stall request
//   stallreq_mem_o  combinational data stall request
//   timeout_o       one-cycle pulse when a transaction is aborted
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int          TIMEOUT  = 16,           // max busy cycles before abort (>= 2)
   parameter int          CNT_W    = 5,            // 2**CNT_W > TIMEOUT
   parameter logic [31:0] NOP_INST = 32'h00000000  // returned to IF on abort
) (
   input  logic        clk,
   input  logic        rst,
   // instruction-fetch port
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_data_o,
   output logic        if_ack_o,
   // data-access port
   input  logic        mem_req_i,
   input  logic        mem_we_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   output logic [31:0] mem_rdata_o,
   output logic        mem_ack_o,
   // memory bus
   output logic        bus_ce_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i,
   // pipeline control
   output logic        stallreq_if_o,
   output logic        stallreq_mem_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MEM_BUSY = 2'd1,
      ST_IF_BUSY  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   // registered state and outputs
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_bus_ce;
   logic             r_bus_we;
   logic [3:0]       r_bus_sel;
   logic [31:0]      r_bus_addr;
   logic [31:0]      r_bus_wdata;
   logic             r_if_ack;
   logic [31:0]      r_if_data;
   logic             r_mem_ack;
   logic [31:0]      r_mem_rdata;
   logic             r_timeout;

   // next-state values
   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_bus_ce_nxt;
   logic             w_bus_we_nxt;
   logic [3:0]       w_bus_sel_nxt;
   logic [31:0]      w_bus_addr_nxt;
   logic [31:0]      w_bus_wdata_nxt;
   logic             w_if_ack_nxt;
   logic [31:0]      w_if_data_nxt;
   logic             w_mem_ack_nxt;
   logic [31:0]      w_mem_rdata_nxt;
   logic             w_timeout_nxt;

   // NOTE: every signal gets a default before the case statement, so no path
   // through this block leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_bus_ce_nxt    = r_bus_ce;
      w_bus_we_nxt    = r_bus_we;
      w_bus_sel_nxt   = r_bus_sel;
      w_bus_addr_nxt  = r_bus_addr;
      w_bus_wdata_nxt = r_bus_wdata;
      w_if_ack_nxt    = 1'b0;
      w_if_data_nxt   = r_if_data;
      w_mem_ack_nxt   = 1'b0;
      w_mem_rdata_nxt = r_mem_rdata;
      w_timeout_nxt   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // bus_ack_i is deliberately ignored here: no transaction owns it
            w_cnt_nxt = '0;
            if (mem_req_i) begin
               w_bus_ce_nxt    = 1'b1;
               w_bus_we_nxt    = mem_we_i;
               w_bus_sel_nxt   = mem_sel_i;
               w_bus_addr_nxt  = mem_addr_i;
               w_bus_wdata_nxt = mem_wdata_i;
               w_state_nxt     = ST_MEM_BUSY;
            end else if (if_req_i) begin
               w_bus_ce_nxt    = 1'b1;
               w_bus_we_nxt    = 1'b0;
               w_bus_sel_nxt   = 4'hF;
               w_bus_addr_nxt  = if_addr_i;
               w_bus_wdata_nxt = 32'h0;
               w_state_nxt     = ST_IF_BUSY;
            end else begin
               w_bus_ce_nxt    = 1'b0;
            end
         end

         ST_MEM_BUSY, ST_IF_BUSY: begin
            // Bus outputs hold their defaults while busy. Ack is checked
            // before the watchdog so a last-cycle ack is never reported as
            // a timeout.
            if (bus_ack_i) begin
               if (r_state == ST_MEM_BUSY) begin
                  w_mem_ack_nxt   = 1'b1;
                  w_mem_rdata_nxt = r_bus_we ? 32'h0 : bus_rdata_i;
               end else begin
                  w_if_ack_nxt    = 1'b1;
                  w_if_data_nxt   = bus_rdata_i;
               end
               w_bus_ce_nxt = 1'b0;
               w_cnt_nxt    = '0;
               w_state_nxt  = ST_IDLE;
            end else if (r_cnt == CNT_LAST) begin
               if (r_state == ST_MEM_BUSY) begin
                  w_mem_ack_nxt   = 1'b1;
                  w_mem_rdata_nxt = 32'h0;
               end else begin
                  w_if_ack_nxt    = 1'b1;
                  w_if_data_nxt   = NOP_INST;
               end
               w_timeout_nxt = 1'b1;
               w_bus_ce_nxt  = 1'b0;
               w_cnt_nxt     = '0;
               w_state_nxt   = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         default: begin
            w_bus_ce_nxt = 1'b0;
            w_cnt_nxt    = '0;
            w_state_nxt  = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_bus_ce    <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_sel   <= 4'h0;
         r_bus_addr  <= 32'h0;
         r_bus_wdata <= 32'h0;
         r_if_ack    <= 1'b0;
         r_if_data   <= 32'h0;
         r_mem_ack   <= 1'b0;
         r_mem_rdata <= 32'h0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bus_ce    <= w_bus_ce_nxt;
         r_bus_we    <= w_bus_we_nxt;
         r_bus_sel   <= w_bus_sel_nxt;
         r_bus_addr  <= w_bus_addr_nxt;
         r_bus_wdata <= w_bus_wdata_nxt;
         r_if_ack    <= w_if_ack_nxt;
         r_if_data   <= w_if_data_nxt;
         r_mem_ack   <= w_mem_ack_nxt;
         r_mem_rdata <= w_mem_rdata_nxt;
         r_timeout   <= w_timeout_nxt;
      end
   end

   assign bus_ce_o    = r_bus_ce;
   assign bus_we_o    = r_bus_we;
   assign bus_sel_o   = r_bus_sel;
   assign bus_addr_o  = r_bus_addr;
   assign bus_wdata_o = r_bus_wdata;
   assign if_ack_o    = r_if_ack;
   assign if_data_o   = r_if_data;
   assign mem_ack_o   = r_mem_ack;
   assign mem_rdata_o = r_mem_rdata;
   assign timeout_o   = r_timeout;

   // Stall requests are combinational so the pipeline is released in the
   // very cycle the ack arrives.
   assign stallreq_if_o  = if_req_i  & ~r_if_ack;
   assign stallreq_mem_o = mem_req_i & ~r_mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int          TIMEOUT = 16;
   localparam int          CNT_W   = 5;
   localparam logic [31:0] TB_NOP  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_data_o;
   logic        if_ack_o;
   logic        mem_req_i;
   logic        mem_we_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [31:0] mem_rdata_o;
   logic        mem_ack_o;
   logic        bus_ce_o;
   logic        bus_we_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;
   logic        stallreq_if_o;
   logic        stallreq_mem_o;
   logic        timeout_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // model of the last value each data output should be holding
   logic [31:0] m_if_last  = 32'h0;
   logic [31:0] m_mem_last = 32'h0;

   mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .NOP_INST(TB_NOP)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
      .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
      .bus_ce_o(bus_ce_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
      .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
      .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL global_time_limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   // what one transaction looked like from outside
   typedef struct {
      int          lat;          // edges from request to ack (-1: none)
      int          ce_cycles;
      int          ack_cyc;
      logic [31:0] data;
      logic        to;
      logic        to_early;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        bus_bad;      // bus changed while ce high
      logic        stall_bad;    // owner stall not high while waiting
      logic        other_stall_bad;
      logic        other_ack;
      logic        ce_at_ack;
      logic        stall_at_ack;
      logic        ack_after;
      logic        to_after;
   } obs_t;

   typedef struct {
      int          lat;
      int          ce_cycles;
      logic [31:0] data;
      logic        to;
   } exp_t;

   // Reference: a slave that answers after `waits` wait states; anything at
   // or beyond TIMEOUT wait states never answers in time.
   function automatic exp_t model(input bit is_mem, input bit we, input logic [31:0] rdata,
                                  input int waits);
      exp_t m;
      bit   timed = (waits >= TIMEOUT);
      m.ce_cycles = timed ? TIMEOUT : waits + 1;
      m.lat       = m.ce_cycles + 1;
      m.to        = timed;
      if (timed)              m.data = is_mem ? 32'h0 : TB_NOP;
      else if (is_mem && we)  m.data = 32'h0;
      else                    m.data = rdata;
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one request, plays the slave, and records what happened.
   // hold: leave req high after the ack; tail: spend one more cycle after ack.
   task automatic run_txn(input bit is_mem, input bit we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                          input logic [31:0] rdata, input bit flush, input bit hold,
                          input bit tail, output obs_t o);
      logic own_ack, own_stall, own_req, oth_ack, oth_stall, oth_req;
      o = '{lat: -1, ce_cycles: 0, ack_cyc: 0, data: 32'h0, to: 1'b0, to_early: 1'b0,
            we: 1'b0, sel: 4'h0, addr: 32'h0, wdata: 32'h0, bus_bad: 1'b0, stall_bad: 1'b0,
            other_stall_bad: 1'b0, other_ack: 1'b0, ce_at_ack: 1'b0, stall_at_ack: 1'b0,
            ack_after: 1'b0, to_after: 1'b0};
      if (is_mem) begin
         mem_req_i = 1'b1; mem_we_i = we; mem_sel_i = sel; mem_addr_i = addr; mem_wdata_i = wdata;
      end else begin
         if_req_i = 1'b1; if_addr_i = addr;
      end
      bus_ack_i = 1'b0;
      for (int t = 1; t <= TIMEOUT + 8; t++) begin
         tick();
         if (flush && t == 1) begin
            if (is_mem) mem_req_i = 1'b0; else if_req_i = 1'b0;
            #1;
         end
         own_ack   = is_mem ? mem_ack_o      : if_ack_o;
         own_stall = is_mem ? stallreq_mem_o : stallreq_if_o;
         oth_ack   = is_mem ? if_ack_o       : mem_ack_o;
         oth_stall = is_mem ? stallreq_if_o  : stallreq_mem_o;
         oth_req   = is_mem ? if_req_i       : mem_req_i;
         if (oth_ack) o.other_ack = 1'b1;
         if (oth_req && !oth_stall) o.other_stall_bad = 1'b1;
         if (bus_ce_o) begin
            if (o.ce_cycles == 0) begin
               o.we = bus_we_o; o.sel = bus_sel_o; o.addr = bus_addr_o; o.wdata = bus_wdata_o;
            end else if (bus_we_o !== o.we || bus_sel_o !== o.sel ||
                         bus_addr_o !== o.addr || bus_wdata_o !== o.wdata) begin
               o.bus_bad = 1'b1;
            end
            o.ce_cycles++;
         end
         if (own_ack) begin
            o.lat = t; o.ack_cyc = cyc; o.data = is_mem ? mem_rdata_o : if_data_o;
            o.to = timeout_o; o.ce_at_ack = bus_ce_o; o.stall_at_ack = own_stall;
            break;
         end
         if (timeout_o) o.to_early = 1'b1;
         own_req = is_mem ? mem_req_i : if_req_i;
         if (own_stall !== own_req) o.stall_bad = 1'b1;
         if (bus_ce_o && o.ce_cycles == waits + 1) begin
            bus_ack_i = 1'b1; bus_rdata_i = rdata;
         end else begin
            bus_ack_i = 1'b0; bus_rdata_i = $urandom;
         end
      end
      bus_ack_i = 1'b0;
      if (!hold) begin
         if (is_mem) mem_req_i = 1'b0; else if_req_i = 1'b0;
      end
      if (tail) begin
         tick();
         o.ack_after = is_mem ? mem_ack_o : if_ack_o;
         o.to_after  = timeout_o;
      end
   endtask

   task automatic test_reset();
      #1;
      checks++; if ({bus_ce_o, bus_we_o, bus_sel_o, if_ack_o, mem_ack_o, timeout_o} !== 9'h0) begin
         failures++; $display("FAIL reset_ctrl got=%h exp=0", {bus_ce_o, bus_we_o, bus_sel_o, if_ack_o, mem_ack_o, timeout_o}); end
      checks++; if ({bus_addr_o, bus_wdata_o, if_data_o, mem_rdata_o} !== 128'h0) begin
         failures++; $display("FAIL reset_data got=%h exp=0", {bus_addr_o, bus_wdata_o, if_data_o, mem_rdata_o}); end
      tick(); tick();
      rst = 1'b0;
      tick();
      checks++; if (bus_ce_o !== 1'b0) begin failures++; $display("FAIL reset_idle_ce got=%b exp=0", bus_ce_o); end
   endtask

   task automatic test_zero_wait_fetch();
      obs_t o; exp_t e;
      e = model(0, 0, 32'h3401_1100, 0);
      run_txn(0, 0, 4'h0, 32'h10, 32'h0, 0, 32'h3401_1100, 0, 0, 1, o);
      m_if_last = e.data;
      checks++; if (o.lat !== e.lat) begin failures++; $display("FAIL zw_fetch latency got=%0d exp=%0d", o.lat, e.lat); end
      checks++; if (o.data !== e.data) begin failures++; $display("FAIL zw_fetch data got=%h exp=%h", o.data, e.data); end
      checks++; if (o.ce_cycles !== 1) begin failures++; $display("FAIL zw_fetch ce_cycles got=%0d exp=1", o.ce_cycles); end
      checks++; if ({o.we, o.sel, o.addr, o.wdata} !== {1'b0, 4'hF, 32'h10, 32'h0}) begin
         failures++; $display("FAIL zw_fetch bus got=%b/%h/%h/%h exp=0/f/10/0", o.we, o.sel, o.addr, o.wdata); end
      checks++; if (o.stall_at_ack !== 1'b0 || o.stall_bad) begin
         failures++; $display("FAIL zw_fetch stall got=%b/%b exp=0/0", o.stall_at_ack, o.stall_bad); end
      checks++; if (o.ack_after !== 1'b0) begin failures++; $display("FAIL zw_fetch ack_pulse got=%b exp=0", o.ack_after); end
   endtask

   task automatic test_contention();
      obs_t om, oi; exp_t em, ei;
      em = model(1, 0, 32'hDEAD_BEEF, 0);
      ei = model(0, 0, 32'h1111_2222, 0);
      if_req_i = 1'b1; if_addr_i = 32'h30;
      run_txn(1, 0, 4'hF, 32'h20, 32'h0, 0, 32'hDEAD_BEEF, 0, 0, 0, om);
      checks++; if (om.lat !== em.lat || om.addr !== 32'h20) begin
         failures++; $display("FAIL cont_mem_first lat/addr got=%0d/%h exp=%0d/20", om.lat, om.addr, em.lat); end
      checks++; if (om.data !== em.data) begin failures++; $display("FAIL cont_mem_data got=%h exp=%h", om.data, em.data); end
      checks++; if (om.other_stall_bad || om.other_ack) begin
         failures++; $display("FAIL cont_if_stall got=%b/%b exp=0/0", om.other_stall_bad, om.other_ack); end
      checks++; if (om.ce_at_ack !== 1'b0) begin failures++; $display("FAIL cont_idle_gap ce got=%b exp=0", om.ce_at_ack); end
      run_txn(0, 0, 4'h0, 32'h30, 32'h0, 0, 32'h1111_2222, 0, 0, 1, oi);
      m_if_last = ei.data; m_mem_last = em.data;
      checks++; if (oi.lat !== ei.lat || oi.addr !== 32'h30) begin
         failures++; $display("FAIL cont_if_second lat/addr got=%0d/%h exp=%0d/30", oi.lat, oi.addr, ei.lat); end
      checks++; if (oi.data !== ei.data || oi.stall_bad) begin
         failures++; $display("FAIL cont_if_data got=%h stall_bad=%b exp=%h", oi.data, oi.stall_bad, ei.data); end
   endtask

   task automatic test_wait_states();
      obs_t o; exp_t e;
      e = model(1, 1, 32'hFFFF_FFFF, 3);
      run_txn(1, 1, 4'b0011, 32'h40, 32'hA5A5_A5A5, 3, 32'hFFFF_FFFF, 0, 0, 1, o);
      m_mem_last = e.data;
      checks++; if (o.ce_cycles !== e.ce_cycles || o.bus_bad) begin
         failures++; $display("FAIL ws_bus_stable ce=%0d bad=%b exp=%0d/0", o.ce_cycles, o.bus_bad, e.ce_cycles); end
      checks++; if ({o.we, o.sel, o.addr, o.wdata} !== {1'b1, 4'b0011, 32'h40, 32'hA5A5_A5A5}) begin
         failures++; $display("FAIL ws_bus_val got=%b/%h/%h/%h exp=1/3/40/a5a5a5a5", o.we, o.sel, o.addr, o.wdata); end
      checks++; if (o.lat !== e.lat || o.ack_after !== 1'b0) begin
         failures++; $display("FAIL ws_ack lat=%0d after=%b exp=%0d/0", o.lat, o.ack_after, e.lat); end
      checks++; if (o.data !== e.data) begin failures++; $display("FAIL ws_wr_rdata got=%h exp=%h", o.data, e.data); end
   endtask

   task automatic test_timeout();
      obs_t o; exp_t e;
      e = model(0, 0, 32'h0, TIMEOUT);
      run_txn(0, 0, 4'h0, 32'h50, 32'h0, TIMEOUT, 32'h0, 0, 0, 1, o);
      m_if_last = e.data;
      checks++; if (o.lat !== e.lat || o.ce_cycles !== e.ce_cycles) begin
         failures++; $display("FAIL to_latency lat=%0d ce=%0d exp=%0d/%0d", o.lat, o.ce_cycles, e.lat, e.ce_cycles); end
      checks++; if (o.data !== e.data) begin failures++; $display("FAIL to_nop got=%h exp=%h", o.data, e.data); end
      checks++; if (o.to !== 1'b1 || o.to_after !== 1'b0 || o.to_early) begin
         failures++; $display("FAIL to_pulse got=%b/%b/%b exp=1/0/0", o.to, o.to_after, o.to_early); end
      checks++; if (o.ce_at_ack !== 1'b0) begin failures++; $display("FAIL to_ce_low got=%b exp=0", o.ce_at_ack); end
      // ack in the very cycle the watchdog would fire: ack wins
      e = model(0, 0, 32'hCAFE_0001, TIMEOUT - 1);
      run_txn(0, 0, 4'h0, 32'h54, 32'h0, TIMEOUT - 1, 32'hCAFE_0001, 0, 0, 1, o);
      m_if_last = e.data;
      checks++; if (o.lat !== e.lat || o.data !== e.data || o.to !== 1'b0) begin
         failures++; $display("FAIL to_ack_wins lat=%0d data=%h to=%b exp=%0d/%h/0", o.lat, o.data, o.to, e.lat, e.data); end
      e = model(0, 0, 32'h0000_1234, 0);
      run_txn(0, 0, 4'h0, 32'h58, 32'h0, 0, 32'h0000_1234, 0, 0, 1, o);
      m_if_last = e.data;
      checks++; if (o.lat !== e.lat || o.data !== e.data || o.to !== 1'b0) begin
         failures++; $display("FAIL to_recover lat=%0d data=%h exp=%0d/%h", o.lat, o.data, e.lat, e.data); end
   endtask

   task automatic test_reset_mid();
      obs_t o; exp_t e;
      mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hF;
      mem_addr_i = 32'h80; mem_wdata_i = 32'h1234_5678; bus_ack_i = 1'b0;
      tick(); tick();
      checks++; if (bus_ce_o !== 1'b1 || bus_addr_o !== 32'h80) begin
         failures++; $display("FAIL rm_busy ce=%b addr=%h exp=1/80", bus_ce_o, bus_addr_o); end
      rst = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
      #1;
      checks++; if ({bus_ce_o, bus_we_o, bus_sel_o, if_ack_o, mem_ack_o, timeout_o} !== 9'h0) begin
         failures++; $display("FAIL rm_async_ctrl got=%h exp=0", {bus_ce_o, bus_we_o, bus_sel_o, if_ack_o, mem_ack_o, timeout_o}); end
      checks++; if ({bus_addr_o, bus_wdata_o, if_data_o, mem_rdata_o} !== 128'h0) begin
         failures++; $display("FAIL rm_async_data got=%h exp=0", {bus_addr_o, bus_wdata_o, if_data_o, mem_rdata_o}); end
      m_if_last = 32'h0; m_mem_last = 32'h0;
      mem_req_i = 1'b0;
      tick();
      bus_ack_i = 1'b0; rst = 1'b0;
      tick();
      checks++; if (mem_ack_o !== 1'b0 || bus_ce_o !== 1'b0) begin
         failures++; $display("FAIL rm_no_ack ack=%b ce=%b exp=0/0", mem_ack_o, bus_ce_o); end
      e = model(1, 0, 32'h0BAD_F00D, 0);
      run_txn(1, 0, 4'hF, 32'h84, 32'h0, 0, 32'h0BAD_F00D, 0, 0, 1, o);
      m_mem_last = e.data;
      checks++; if (o.lat !== e.lat || o.data !== e.data) begin
         failures++; $display("FAIL rm_fresh lat=%0d data=%h exp=%0d/%h", o.lat, o.data, e.lat, e.data); end
   endtask

   task automatic test_back_to_back();
      obs_t o[3]; exp_t e;
      logic [31:0] img [3];
      for (int i = 0; i < 3; i++) img[i] = $urandom;
      for (int i = 0; i < 3; i++)
         run_txn(0, 0, 4'h0, 32'(4 * i), 32'h0, 0, img[i], 0, (i < 2), (i == 2), o[i]);
      for (int i = 0; i < 3; i++) begin
         e = model(0, 0, img[i], 0);
         checks++; if (o[i].lat !== e.lat || o[i].addr !== 32'(4 * i) || o[i].data !== e.data) begin
            failures++; $display("FAIL b2b_%0d lat=%0d addr=%h data=%h exp=%0d/%h/%h", i, o[i].lat, o[i].addr, o[i].data, e.lat, 4 * i, e.data); end
      end
      checks++; if (o[1].ack_cyc - o[0].ack_cyc !== 2 || o[2].ack_cyc - o[1].ack_cyc !== 2) begin
         failures++; $display("FAIL b2b_spacing got=%0d/%0d exp=2/2", o[1].ack_cyc - o[0].ack_cyc, o[2].ack_cyc - o[1].ack_cyc); end
      m_if_last = img[2];
   endtask

   task automatic test_idle_ack_and_hold();
      for (int i = 0; i < 4; i++) begin
         bus_ack_i = 1'b1; bus_rdata_i = $urandom;
         tick();
      end
      bus_ack_i = 1'b0;
      checks++; if (bus_ce_o !== 1'b0 || if_ack_o !== 1'b0 || mem_ack_o !== 1'b0) begin
         failures++; $display("FAIL idle_ack ce=%b ifack=%b memack=%b exp=0/0/0", bus_ce_o, if_ack_o, mem_ack_o); end
      checks++; if (if_data_o !== m_if_last || mem_rdata_o !== m_mem_last) begin
         failures++; $display("FAIL idle_hold got=%h/%h exp=%h/%h", if_data_o, mem_rdata_o, m_if_last, m_mem_last); end
   endtask

   task automatic test_random();
      obs_t o; exp_t e;
      bit is_mem, we, flush; int waits, r; logic [3:0] sel; logic [31:0] addr, wdata, rdata;
      for (int i = 0; i < 25; i++) begin
         is_mem = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
         sel = 4'($urandom); addr = $urandom & 32'hFFFF_FFFC; wdata = $urandom; rdata = $urandom;
         r = $urandom_range(0, 9);
         waits = (r == 9) ? TIMEOUT : (r == 8) ? TIMEOUT - 1 : $urandom_range(0, 4);
         flush = ($urandom_range(0, 5) == 0);
         e = model(is_mem, we, rdata, waits);
         run_txn(is_mem, we, sel, addr, wdata, waits, rdata, flush, 0, 1, o);
         if (is_mem) m_mem_last = e.data; else m_if_last = e.data;
         checks++; if (o.lat !== e.lat || o.ce_cycles !== e.ce_cycles) begin
            failures++; $display("FAIL rnd%0d timing lat=%0d ce=%0d exp=%0d/%0d", i, o.lat, o.ce_cycles, e.lat, e.ce_cycles); end
         checks++; if (o.data !== e.data || o.to !== e.to || o.to_early || o.to_after) begin
            failures++; $display("FAIL rnd%0d result data=%h to=%b exp=%h/%b", i, o.data, o.to, e.data, e.to); end
         checks++; if (o.addr !== addr || o.we !== (is_mem & we) || o.sel !== (is_mem ? sel : 4'hF) ||
                       o.wdata !== (is_mem ? wdata : 32'h0) || o.bus_bad) begin
            failures++; $display("FAIL rnd%0d bus got=%b/%h/%h/%h bad=%b", i, o.we, o.sel, o.addr, o.wdata, o.bus_bad); end
         checks++; if (o.stall_bad || o.other_ack || o.ack_after || o.ce_at_ack) begin
            failures++; $display("FAIL rnd%0d ctrl stall=%b oth=%b after=%b ce=%b exp=0", i, o.stall_bad, o.other_ack, o.ack_after, o.ce_at_ack); end
         checks++; if (if_data_o !== m_if_last || mem_rdata_o !== m_mem_last) begin
            failures++; $display("FAIL rnd%0d hold got=%h/%h exp=%h/%h", i, if_data_o, mem_rdata_o, m_if_last, m_mem_last); end
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      if_req_i = 1'b0; if_addr_i = 32'h0;
      mem_req_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0; mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
      bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
      test_reset();
      test_zero_wait_fetch();
      test_contention();
      test_wait_states();
      test_timeout();
      test_idle_ack_and_hold();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_idle_ack_and_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
